// File: rtl/sar_adc_pkg.sv
// Shared definitions for consumers of the 10-bit SAR ADC core.
package sar_adc_pkg;

    // Result width of the SAR core
    localparam int NOB_DEF = 10;

    typedef enum logic {
        COLLECT = 1'b0,
        COMMIT  = 1'b1
    } avg_state_t;

    // Accumulator width that holds 2^log2_avg full-scale samples without overflow
    function automatic int acc_width(input int nob, input int log2_avg);
        return nob + log2_avg;
    endfunction

endpackage

// File: rtl/sar_eoc_edge.sv
// EOC rising-edge detector: a level EOC held high counts as one sample.
module sar_eoc_edge (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic eoc,
    output logic take
);

    logic eoc_q;

    // Previous-cycle EOC level, tracked regardless of enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) eoc_q <= 1'b0;
        else      eoc_q <= eoc;
    end

    assign take = en && eoc && !eoc_q;

endmodule

// File: rtl/sar_avg_collector.sv
// Averages 2^LOG2_AVG SAR conversions and offers the result over valid/ready.
// Optional macro SAR_AVG_ROUND_EN selects round-half-up (saturated) instead of truncation.
module sar_avg_collector
    import sar_adc_pkg::*;
#(
    parameter int NOB      = NOB_DEF,
    parameter int LOG2_AVG = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NOB-1:0]      adc_data,
    input  logic                adc_eoc,
    output logic [NOB-1:0]      avg_data,
    output logic                avg_valid,
    input  logic                avg_ready,
    output logic [LOG2_AVG-1:0] smp_cnt,
    output logic                overrun,
    input  logic                ovr_clr
);

    localparam int ACC_W = acc_width(NOB, LOG2_AVG);
    localparam logic [LOG2_AVG-1:0] CNT_LAST = '1;
    localparam logic [LOG2_AVG-1:0] CNT_ONE  = LOG2_AVG'(1);

    avg_state_t       state, state_nxt;
    logic             take;
    logic             commit;
    logic [ACC_W-1:0] acc;
    logic [NOB-1:0]   avg_calc;

    sar_eoc_edge u_eoc_edge (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .eoc  (adc_eoc),
        .take (take)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= COLLECT;
        else      state <= state_nxt;
    end

    // Next state: COMMIT lasts exactly one cycle after the last sample of a block
    always_comb begin
        state_nxt = COLLECT;
        commit    = (state == COMMIT);
        if (en && take && (smp_cnt == CNT_LAST))
            state_nxt = COMMIT;
    end

    // Accumulator and sample counter; count 0 means "first of block, load".
    // During COMMIT the count has already wrapped, so a new edge starts the next block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            smp_cnt <= '0;
        end else if (!en) begin
            acc     <= '0;
            smp_cnt <= '0;
        end else if (take) begin
            acc     <= (smp_cnt == '0) ? ACC_W'(adc_data) : acc + ACC_W'(adc_data);
            smp_cnt <= smp_cnt + CNT_ONE;
        end
    end

`ifdef SAR_AVG_ROUND_EN
    localparam logic [ACC_W:0] RND_HALF = (ACC_W+1)'(1) << (LOG2_AVG - 1);
    logic [ACC_W:0]        sum_rnd;
    logic [NOB:0]          avg_wide;
    logic [LOG2_AVG-1:0]   lsb_unused;

    // Round half up, clamp to full scale
    always_comb begin
        sum_rnd    = {1'b0, acc} + RND_HALF;
        avg_wide   = sum_rnd[ACC_W:LOG2_AVG];
        lsb_unused = sum_rnd[LOG2_AVG-1:0];
        avg_calc   = avg_wide[NOB] ? '1 : avg_wide[NOB-1:0];
    end
`else
    logic [LOG2_AVG-1:0] lsb_unused;

    // Truncating divide by 2^LOG2_AVG
    always_comb begin
        avg_calc   = acc[ACC_W-1:LOG2_AVG];
        lsb_unused = acc[LOG2_AVG-1:0];
    end
`endif

    // Output register: load on commit if free or being drained this cycle, else flag overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            avg_data  <= '0;
            avg_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (commit && (!avg_valid || avg_ready)) begin
                avg_data  <= avg_calc;
                avg_valid <= 1'b1;
            end else if (avg_valid && avg_ready) begin
                avg_valid <= 1'b0;
            end
            if (commit && avg_valid && !avg_ready) overrun <= 1'b1;
            else if (ovr_clr)                      overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sar_avg_collector.sv
// Self-checking bench for sar_avg_collector (NOB=10, LOG2_AVG=2).
module tb_sar_avg_collector;

    localparam int NOB = 10;
    localparam int L2  = 2;
    localparam int N   = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en = 1'b0;
    logic [NOB-1:0] adc_data = '0;
    logic           adc_eoc = 1'b0;
    logic [NOB-1:0] avg_data;
    logic           avg_valid;
    logic           avg_ready = 1'b0;
    logic [L2-1:0]  smp_cnt;
    logic           overrun;
    logic           ovr_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    int cur[$];      // samples of the block in progress
    int exp_q[$];    // expected accepted averages
    int got_q[$];    // averages actually accepted by the consumer

    sar_avg_collector #(.NOB(NOB), .LOG2_AVG(L2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .adc_data  (adc_data),
        .adc_eoc   (adc_eoc),
        .avg_data  (avg_data),
        .avg_valid (avg_valid),
        .avg_ready (avg_ready),
        .smp_cnt   (smp_cnt),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    // Consumer side: record every accepted result
    always @(posedge clk)
        if (rst && avg_valid && avg_ready) got_q.push_back(int'(avg_data));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: mean of a block, truncated or rounded-half-up and clamped
    function automatic int model_avg(input int s[$]);
        int sum = 0;
        int r;
        foreach (s[i]) sum += s[i];
`ifdef SAR_AVG_ROUND_EN
        r = (sum + N / 2) / N;
        if (r > (1 << NOB) - 1) r = (1 << NOB) - 1;
`else
        r = sum / N;
`endif
        return r;
    endfunction

    // One conversion: EOC high for 'hold' cycles then low for 'gap' cycles
    task automatic send(input int d, input int hold = 1, input int gap = 1);
        adc_data = NOB'(d);
        adc_eoc  = 1'b1;
        repeat (hold) tick();
        adc_eoc  = 1'b0;
        repeat (gap) tick();
        cur.push_back(d);
    endtask

    // Block complete and expected to be delivered
    task automatic close_blk;
        exp_q.push_back(model_avg(cur));
        cur.delete();
    endtask

    task automatic check_results(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int v;
        // Reset state
        repeat (3) tick();
        check("rst_valid", avg_valid, 0);
        check("rst_data", avg_data, 0);
        check("rst_cnt", smp_cnt, 0);
        check("rst_ovr", overrun, 0);
        rst = 1'b1; en = 1'b1; avg_ready = 1'b1;
        tick();

        // Four conversions of 512, latency and single-cycle valid
        repeat (3) send(512);
        adc_data = 10'd512; adc_eoc = 1'b1;
        tick();
        adc_eoc = 1'b0;
        check("lat_1clk_valid", avg_valid, 0);
        tick();
        check("lat_2clk_valid", avg_valid, 1);
        check("lat_2clk_data", avg_data, 512);
        cur.push_back(512);
        close_blk();
        tick();
        check("lat_drop_valid", avg_valid, 0);
        check("lat_cnt", smp_cnt, 0);
        check_results("blk512");

        // Truncation vs rounding, and full-scale without wrap
        send(1); send(2); send(2); send(2); close_blk();
        send(1023); send(1023); send(1023); send(1023); close_blk();
        tick();
        check_results("round");

        // EOC held 3 cycles per conversion counts once
        for (int i = 0; i < N; i++) begin
            send($urandom_range(0, 1023), 3, 1);
            check($sformatf("hold_cnt_%0d", i), smp_cnt, (i + 1) % N);
        end
        close_blk();
        tick();
        check_results("hold3");

        // Stalled consumer: second block dropped, overrun sticky
        avg_ready = 1'b0;
        repeat (4) send(100);
        close_blk();
        check("ovr_valid1", avg_valid, 1);
        repeat (4) send(200);
        cur.delete();
        check("ovr_data", avg_data, 100);
        check("ovr_flag", overrun, 1);
        check("ovr_valid2", avg_valid, 1);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        check("ovr_clr", overrun, 0);
        avg_ready = 1'b1;
        tick();
        check("ovr_accept", avg_valid, 0);
        check_results("ovr");

        // en low discards a partial block
        send(55); send(55);
        check("en_cnt_before", smp_cnt, 2);
        cur.delete();
        en = 1'b0; tick(); en = 1'b1;
        check("en_cnt_after", smp_cnt, 0);
        repeat (4) send(300);
        close_blk();
        tick();
        check_results("en");

        // Reset mid-block with a pending result
        avg_ready = 1'b0;
        repeat (4) send(50);
        cur.delete();
        repeat (3) send(9);
        cur.delete();
        check("mid_cnt", smp_cnt, 3);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", avg_valid, 0);
        check("mid_rst_data", avg_data, 0);
        check("mid_rst_cnt", smp_cnt, 0);
        avg_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        repeat (3) send(7);
        check("post_rst_valid", avg_valid, 0);
        send(7);
        check("post_rst_data", avg_data, 7);
        close_blk();
        tick();
        check_results("rst");

        // Randomized blocks with varying EOC widths and gaps
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < N; i++) begin
                v = $urandom_range(0, 1023);
                send(v, $urandom_range(1, 3), $urandom_range(1, 2));
                check($sformatf("rnd_cnt_%0d_%0d", b, i), smp_cnt, (i + 1) % N);
            end
            close_blk();
        end
        repeat (3) tick();
        check_results("rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sar_avg_collector.md
Name: sar_avg_collector

Overview:
- Downstream consumer of the 10-bit SAR ADC core; captures `digital_out` on each end-of-conversion and accumulates 2^LOG2_AVG consecutive conversions.
- Emits the block average to the system side over a valid/ready handshake.
- Double-buffered (accumulator + output register) so conversions keep flowing while the consumer stalls; overruns are flagged sticky.

Parameters:
- NOB, 10, ADC result width (matches the SAR core).
- LOG2_AVG, 2, log2 of samples per average; legal range 1..6.

Ports:
- clk  in  1  system clock (same clock as the SAR core)
- rst  in  1  asynchronous, active-low reset
- en  in  1  collection enable; low discards the partial block
- adc_data  in  NOB  SAR core `digital_out`
- adc_eoc  in  1  SAR core `EOC`; level signal, may stay high multiple cycles
- avg_data  out  NOB  averaged result
- avg_valid  out  1  avg_data holds an unconsumed result
- avg_ready  in  1  consumer accepts when avg_valid && avg_ready at clk rise
- smp_cnt  out  LOG2_AVG  samples accumulated in the current block
- overrun  out  1  sticky: a completed block was dropped
- ovr_clr  in  1  synchronous clear of overrun

Behaviour:
- Reset (rst=0, async): all outputs 0; accumulator, edge register and state cleared.
- Sample capture:
  - eoc_q registers adc_eoc each cycle.
  - A sample is taken only on the rising edge (adc_eoc && !eoc_q) with en=1, latching adc_data that cycle.
  - A level held high counts once.
- Accumulator:
  - Width NOB+LOG2_AVG; cannot overflow.
  - First sample of a block loads rather than adds.
- FSM, 2 states:
  - COLLECT: each sample increments smp_cnt. On the 2^LOG2_AVG-th sample, goes to COMMIT for one cycle with the final sum; smp_cnt wraps to 0.
  - COMMIT: computes avg = sum >> LOG2_AVG (truncation). If avg_valid=0, or the handshake completes this same cycle, loads avg_data and sets avg_valid on the next edge; otherwise drops the result and sets overrun. Always returns to COLLECT.
  - A sample edge arriving during COMMIT is accepted as sample 0 of the next block (no loss).
- Latency: avg_valid rises 2 clk after the cycle the final rising edge of adc_eoc is sampled.
- Handshake:
  - avg_valid clears the cycle after acceptance.
  - avg_data is stable while avg_valid=1 && avg_ready=0.
  - Simultaneous accept and new commit: avg_valid stays 1 with the new data.
- en deasserted: smp_cnt and accumulator clear next edge; a pending avg_valid is kept; FSM forced to COLLECT.
- overrun:
  - Set has priority over ovr_clr in the same cycle.
  - Only reset or ovr_clr clears it.
- Reset mid-block: partial sum lost; no spurious avg_valid after release.

Optional Feature:
- Macro SAR_AVG_ROUND_EN.
- Defined: avg = (sum + 2^(LOG2_AVG-1)) >> LOG2_AVG, round-half-up, saturated to 2^NOB-1.
- Undefined: plain truncation; the rounding adder is absent.

Decomposition:
- Shared package `sar_adc_pkg`:
  - NOB default constant
  - FSM state typedef {COLLECT, COMMIT}
  - Function for accumulator width NOB+LOG2_AVG
- One natural sub-module, `sar_eoc_edge`: eoc_q register plus rising-edge/enable qualify, reusable by other SAR consumers.
- Accumulate/FSM/output register stay in the top.

Test Plan:
- NOB=10, LOG2_AVG=2, four conversions of 512, avg_ready=1 → avg_data=512, avg_valid high exactly 1 cycle, 2 clk after the 4th EOC edge.
- Samples 1,2,2,2 (sum 7) → avg_data=1 without macro; avg_data=2 with SAR_AVG_ROUND_EN. Samples all 1023 with macro → 1023, no wrap.
- adc_eoc held high 3 cycles per conversion, 4 conversions → exactly one result; smp_cnt steps 1,2,3,0.
- avg_ready=0, eight conversions (blocks 100s then 200s):
  - avg_data stays 100 and overrun=1.
  - ovr_clr pulse → overrun=0.
  - avg_ready=1 → accepted, avg_valid drops.
- After 2 samples: en=0 one cycle, then 4 samples of 300 → avg_data=300; the earlier partial sum is discarded.
- After 3 samples: assert rst mid-block → outputs 0 immediately; after release, 4 samples of 7 → avg_data=7, no earlier result emitted.
